// File: rtl/wgt_pkg.sv
// wgt_pkg
//   Types and widths shared by the weight-FIFO read controller and its
//   skew sub-module.
//   LEN_W  : width of the per-pass word count (wgt_len)
//   SIZE_W : width of the active-FIFO count (read_wgt_size)
//   PASS_W : width of the pass count (num_pass, multipass builds only)
//   wgt_rd_state_e : controller state encoding
package wgt_pkg;

    localparam int LEN_W  = 13;
    localparam int SIZE_W = 5;
    localparam int PASS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } wgt_rd_state_e;

endpackage

// File: rtl/wgt_fifo_rd_ctrl_rd_en_skew.sv
// rd_en_skew
//   Stallable skew shift register producing the per-FIFO read enables.
//   Bit 0 takes the head read request; bit i is bit i-1 one shift later,
//   so each FIFO reads one cycle after its neighbour (systolic skew).
//   Bits at or above the active size are masked to zero.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     i_shift   : advance the register this cycle
//     i_head    : value shifted into bit 0
//     i_stall   : forces o_rd_en to zero while high (register untouched)
//     i_size    : number of active FIFOs (1..NUM_FIFO)
//     o_rd_en   : per-FIFO read enables
module rd_en_skew
    import wgt_pkg::*;
#(
    parameter int NUM_FIFO = 16,
    parameter int SZ_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_shift,
    input  logic                i_head,
    input  logic                i_stall,
    input  logic [SZ_W-1:0]     i_size,
    output logic [NUM_FIFO-1:0] o_rd_en
);

    logic [NUM_FIFO-1:0] r_sr;
    logic [NUM_FIFO-1:0] w_mask;
    logic [NUM_FIFO-1:0] w_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFO; gi++) begin : g_lane
            assign w_mask[gi] = (gi < int'(i_size));
            if (gi == 0) begin : g_head
                assign w_next[gi] = i_head & w_mask[gi];
            end else begin : g_tail
                assign w_next[gi] = r_sr[gi-1] & w_mask[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_next;
        end
    end

    // Stall must blank the enables in the same cycle it is raised, so the
    // gating is combinational; the frozen register keeps the skew intact.
    assign o_rd_en = i_stall ? '0 : r_sr;

endmodule

// File: rtl/wgt_fifo_rd_ctrl.sv
// wgt_fifo_rd_ctrl
//   Read controller for NUM_FIFO weight FIFOs feeding a systolic array.
//   One job: clear read pointers (CLR), issue wgt_len head reads (RUN),
//   let the skew register empty (DRAIN), then pulse done (FIN).
//   Optional feature macro: WGT_RD_MULTIPASS_EN adds num_pass and repeats
//   CLR/RUN/DRAIN num_pass times per job.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     start         : job request, sampled only while idle
//     wgt_len       : words per FIFO per pass (clamped to MAX_WGT_FIFO_SIZE)
//     read_wgt_size : active FIFO count (0 or >NUM_FIFO means NUM_FIFO)
//     stall         : freezes read issue while high
//     num_pass      : passes per job, 0 means 1 (multipass builds only)
//     rd_en         : skewed per-FIFO read enables
//     rd_clr        : read-pointer clear pulse
//     busy          : job in progress
//     done          : one-cycle job-complete pulse
module wgt_fifo_rd_ctrl
    import wgt_pkg::*;
#(
    parameter int NUM_FIFO          = 16,
    parameter int MAX_WGT_FIFO_SIZE = 4608
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    wgt_len,
    input  logic [SIZE_W-1:0]   read_wgt_size,
    input  logic                stall,
`ifdef WGT_RD_MULTIPASS_EN
    input  logic [PASS_W-1:0]   num_pass,
`endif
    output logic [NUM_FIFO-1:0] rd_en,
    output logic                rd_clr,
    output logic                busy,
    output logic                done
);

    localparam int SZ_W = $clog2(NUM_FIFO + 1);

    wgt_rd_state_e   r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_head_rem;
    logic [SZ_W-1:0]  r_size;
    logic [SZ_W-1:0]  r_drain_cnt;
    logic             r_rd_clr;
    logic             r_busy;
    logic             r_done;
`ifdef WGT_RD_MULTIPASS_EN
    logic [PASS_W-1:0] r_pass_left;
`endif

    logic [LEN_W-1:0] w_len_eff;
    logic [SZ_W-1:0]  w_size_eff;
    logic             w_last_pass;
    logic             w_shift;
    logic             w_head;

    assign w_len_eff  = (32'(wgt_len) > MAX_WGT_FIFO_SIZE) ? LEN_W'(MAX_WGT_FIFO_SIZE) : wgt_len;
    assign w_size_eff = (read_wgt_size == '0 || 32'(read_wgt_size) > NUM_FIFO)
                        ? SZ_W'(NUM_FIFO) : SZ_W'(read_wgt_size);

`ifdef WGT_RD_MULTIPASS_EN
    assign w_last_pass = (r_pass_left <= PASS_W'(1));
`else
    assign w_last_pass = 1'b1;
`endif

    // CLR seeds the first head read so rd_en[0] rises on the first RUN
    // cycle; RUN keeps feeding ones until the head count runs out.
    assign w_shift = (r_state == ST_CLR) ||
                     (((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !stall);
    assign w_head  = (r_state == ST_CLR) ||
                     ((r_state == ST_RUN) && (r_head_rem != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_head_rem  <= '0;
            r_size      <= '0;
            r_drain_cnt <= '0;
            r_rd_clr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef WGT_RD_MULTIPASS_EN
            r_pass_left <= '0;
`endif
        end else begin
            r_rd_clr <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len  <= w_len_eff;
                        r_size <= w_size_eff;
                        r_busy <= 1'b1;
`ifdef WGT_RD_MULTIPASS_EN
                        r_pass_left <= (num_pass == '0) ? PASS_W'(1) : num_pass;
`endif
                        if (w_len_eff == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= ST_CLR;
                            r_rd_clr <= 1'b1;
                        end
                    end
                end
                ST_CLR: begin
                    // The seed read counts as the first of r_len.
                    r_state    <= ST_RUN;
                    r_head_rem <= r_len - LEN_W'(1);
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (r_head_rem != '0) begin
                            r_head_rem <= r_head_rem - LEN_W'(1);
                        end else if (r_size > SZ_W'(1)) begin
                            // Last head read leaves now; size-1 more shifts
                            // push it through the far lane.
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= r_size - SZ_W'(2);
                        end else if (w_last_pass) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= ST_CLR;
                            r_rd_clr <= 1'b1;
`ifdef WGT_RD_MULTIPASS_EN
                            r_pass_left <= r_pass_left - PASS_W'(1);
`endif
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (r_drain_cnt != '0) begin
                            r_drain_cnt <= r_drain_cnt - SZ_W'(1);
                        end else if (w_last_pass) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= ST_CLR;
                            r_rd_clr <= 1'b1;
`ifdef WGT_RD_MULTIPASS_EN
                            r_pass_left <= r_pass_left - PASS_W'(1);
`endif
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    rd_en_skew #(
        .NUM_FIFO (NUM_FIFO),
        .SZ_W     (SZ_W)
    ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_shift),
        .i_head  (w_head),
        .i_stall (stall),
        .i_size  (r_size),
        .o_rd_en (rd_en)
    );

    assign rd_clr = r_rd_clr;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_wgt_fifo_rd_ctrl.sv
module tb_wgt_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] wgt_len = '0;
    logic [4:0]  read_wgt_size = '0;
    logic        stall = 1'b0;
`ifdef WGT_RD_MULTIPASS_EN
    logic [7:0]  num_pass = 8'd1;
`endif
    logic [15:0] rd_en;
    logic        rd_clr;
    logic        busy;
    logic        done;

    wgt_fifo_rd_ctrl #(
        .NUM_FIFO          (16),
        .MAX_WGT_FIFO_SIZE (4608)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .wgt_len       (wgt_len),
        .read_wgt_size (read_wgt_size),
        .stall         (stall),
`ifdef WGT_RD_MULTIPASS_EN
        .num_pass      (num_pass),
`endif
        .rd_en         (rd_en),
        .rd_clr        (rd_clr),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rd_en;
        logic        rd_clr;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   job_t = 0;
    bit   mon_en = 1'b1;
    exp_t mon_e;
    int   mon_rel;
    int   mon_exp;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: any cycle the DUT shows activity consumes one expected entry.
    always @(negedge clk) begin
        if (!rst && mon_en && (busy || rd_clr || done || (|rd_en))) begin
            mon_rel = edge_cnt + 1 - job_t;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output rel=%0d rd_en=%h rd_clr=%b busy=%b done=%b required=idle",
                         mon_rel, rd_en, rd_clr, busy, done);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_en !== mon_e.rd_en || rd_clr !== mon_e.rd_clr ||
                    done !== mon_e.done || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL trace rel=%0d rd_en=%h/%h rd_clr=%b/%b done=%b/%b busy=%b/1 (actual/required)",
                             mon_rel, rd_en, mon_e.rd_en, rd_clr, mon_e.rd_clr, done, mon_e.done, busy);
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_time rel=%0d required=none", mon_rel);
                end else begin
                    mon_exp = done_q.pop_front();
                    if (mon_rel != mon_exp) begin
                        errors++;
                        $display("FAIL done_time actual=T+%0d required=T+%0d", mon_rel, mon_exp);
                    end
                end
            end
        end
    end

    // Issue one job, push its expected cycle trace and hand-computed done
    // time, then drive it to completion. Stall is high for cycles
    // T+ss .. T+ss+sl-1. Start stays high through T+1 (busy) to check it
    // is ignored; size/len inputs are scrambled after acceptance.
    task automatic do_job(input int len, input int size_in, input int ss, input int sl,
                          input int npass, input int exp_done, input string name);
        int   eff;
        int   np;
        int   k;
        int   rel;
        int   d;
        exp_t e;
        eff = (size_in == 0 || size_in > 16) ? 16 : size_in;
        np  = (npass == 0) ? 1 : npass;
        @(posedge clk); #1;
        wgt_len       = 13'(len);
        read_wgt_size = 5'(size_in);
        start         = 1'b1;
`ifdef WGT_RD_MULTIPASS_EN
        num_pass = 8'(npass);
`endif
        job_t = edge_cnt + 1;
        rel = 1;
        if (len == 0) begin
            e = '{rd_en: 16'h0, rd_clr: 1'b0, done: 1'b1};
            exp_q.push_back(e);
            d = 1;
        end else begin
            for (int p = 0; p < np; p++) begin
                e = '{rd_en: 16'h0, rd_clr: 1'b1, done: 1'b0};
                exp_q.push_back(e);
                rel++;
                k = 0;
                while (k < len + eff - 1) begin
                    e = '{rd_en: 16'h0, rd_clr: 1'b0, done: 1'b0};
                    if (!(rel >= ss && rel < ss + sl)) begin
                        for (int i = 0; i < eff; i++)
                            if (k - i >= 0 && k - i < len) e.rd_en[i] = 1'b1;
                        k++;
                    end
                    exp_q.push_back(e);
                    rel++;
                end
            end
            e = '{rd_en: 16'h0, rd_clr: 1'b0, done: 1'b1};
            exp_q.push_back(e);
            d = rel;
        end
        done_q.push_back(exp_done);
        for (int r = 1; r <= d + 2; r++) begin
            @(posedge clk); #1;
            if (r == 1) begin
                wgt_len       = 13'd7;
                read_wgt_size = 5'd9;
`ifdef WGT_RD_MULTIPASS_EN
                num_pass = 8'd5;
`endif
            end else begin
                start = 1'b0;
            end
            stall = (r >= ss && r < ss + sl);
        end
        stall = 1'b0;
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover expected=%0d done_pending=%0d required=0", name, exp_q.size(), done_q.size());
        end
        exp_q.delete();
        done_q.delete();
        $display("job %s: len=%0d size=%0d stall@%0d+%0d passes=%0d done_exp=T+%0d checks=%0d errors=%0d",
                 name, len, size_in, ss, sl, np, exp_done, checks, errors);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", 32'(rd_en), 32'h0);
        chk("reset_ctrl", {29'h0, rd_clr, busy, done}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_job(4, 16, 0, 0, 1, 21, "len4_size16");
        do_job(2, 3, 0, 0, 1, 6, "len2_size3");
        do_job(4, 2, 3, 2, 1, 9, "stall2_len4_size2");
        do_job(0, 5, 0, 0, 1, 1, "len0");
        do_job(1, 0, 0, 0, 1, 18, "size0_as16");
        do_job(2, 20, 0, 0, 1, 19, "size20_as16");
        do_job(3, 1, 4, 1, 1, 6, "size1_stall");

        // Reset mid-RUN: outputs must clear without a clock edge.
        mon_en = 1'b0;
        @(posedge clk); #1;
        wgt_len = 13'd4; read_wgt_size = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrun_rd_en", 32'(rd_en), 32'h3);
        chk("midrun_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(rd_en), 32'h0);
        chk("async_rst_ctrl", {29'h0, rd_clr, busy, done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        do_job(4, 16, 0, 0, 1, 21, "after_reset");

`ifdef WGT_RD_MULTIPASS_EN
        do_job(3, 1, 0, 0, 2, 9, "multipass2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
